serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, clock cycles per serial bit period (legal range 2..65535).
REQ-002 Parameter: DATA_W, 8, payload bits per frame (legal range 1..16).
REQ-003 Port: clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: send  input  1  one-cycle start pulse from the upstream edge-pulse register stage.
REQ-006 Port: data_in  input  DATA_W  payload, sampled only in the cycle send is accepted.
REQ-007 Port: tx_out  output  1  serial line, idle high, registered.
REQ-008 Port: busy  output  1  high from the cycle after acceptance until frame end.
REQ-009 Port: done  output  1  one-cycle pulse on frame completion.

Function
REQ-010 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when SERIAL_TX_PARITY_EN is defined.
REQ-011 IDLE: tx_out=1, busy=0; send=1 SHALL latch data_in into a shift register, clear counters, and enter START on the same edge.
REQ-012 tx_out SHALL change on the edge that accepts send (no extra latency): START drives tx_out=0.
REQ-013 Every non-IDLE state SHALL hold tx_out for exactly CLKS_PER_BIT cycles, timed by a bit-period counter counting 0..CLKS_PER_BIT-1.
REQ-014 DATA SHALL emit DATA_W bits LSB first, one per bit period, tracked by a bit index counter 0..DATA_W-1.
REQ-015 After the last DATA bit: go to PARITY if enabled, else STOP.
REQ-016 STOP SHALL drive tx_out=1 for one bit period, then return to IDLE, asserting done for exactly the one cycle of that transition.
REQ-017 send asserted while busy=1 or in the done cycle SHALL be ignored; no queuing, and the latched payload SHALL not change.
REQ-018 send held high for several cycles in IDLE SHALL start exactly one frame (acceptance only in IDLE).
REQ-019 Back-to-back: send in the first IDLE cycle after done SHALL be accepted; minimum frame spacing is one idle cycle.
REQ-020 Total frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.

Reset
REQ-021 reset SHALL force IDLE, tx_out=1, busy=0, done=0, and clear all counters and the shift register.
REQ-022 reset mid-frame SHALL abort immediately; the partial frame is not resumed and done is not asserted.
REQ-023 The first send after reset deassertion SHALL be accepted normally.

Configuration
REQ-024 Macro SERIAL_TX_PARITY_EN defined: one even-parity bit (XOR of payload) is inserted between DATA and STOP.
REQ-025 Macro undefined: no PARITY state or parity logic exists; the frame is start, data, stop only.

Structure
REQ-026 A shared package serial_pkg SHALL hold the state enumeration typedef, the default CLKS_PER_BIT and DATA_W constants, and the idle-line level constant.
REQ-027 One sub-module, bit_timer, SHALL implement the bit-period counter with a restart input and a one-cycle period_end output.

Verification
REQ-028 Reset, then idle 50 cycles -> tx_out=1, busy=0, done=0 throughout.
REQ-029 CLKS_PER_BIT=4, send with data_in=8'hA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done pulses at cycle 40.
REQ-030 Parity build, data_in=8'h07 -> parity bit 1; frame 44 cycles; data_in=8'h03 -> parity bit 0.
REQ-031 send again at cycle 10 of an active 8'hA5 frame with data_in=8'hFF -> ignored; transmitted bits remain 8'hA5.
REQ-032 reset asserted at cycle 15 of a frame -> tx_out=1 and busy=0 immediately, no done; next send of 8'h3C transmits fully.
REQ-033 send held high 6 cycles, then a second send in the cycle after done -> exactly two complete frames, second starting one cycle after done.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: state encoding, default parameters and idle line level for serial_frame_tx.
// Defining SERIAL_TX_PARITY_EN adds the PARITY state.
package serial_pkg;
  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam logic LINE_IDLE = 1'b1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: counts 0..CLKS_PER_BIT-1 while run is high, pulsing period_end on the last count.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic period_end
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    period_end = run && cnt_q == CW'(CLKS_PER_BIT - 1);
    cnt_d = (restart || period_end || !run) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start/data(LSB first)/stop serial transmitter with registered line output.
// Defining SERIAL_TX_PARITY_EN inserts an even-parity bit between data and stop.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              send,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IW-1:0] idx_q, idx_d;
  logic tx_q, tx_d, done_q, done_d, accept, period_end;
`ifdef SERIAL_TX_PARITY_EN
  logic par_q, par_d;
`endif
  // the done cycle is an IDLE cycle that still refuses send
  assign accept = state_q == IDLE && send && !done_q;
  assign tx_out = tx_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock(clock),
    .reset(reset),
    .restart(accept),
    .run(busy),
    .period_end(period_end)
  );
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    idx_d = idx_q;
    tx_d = tx_q;
    done_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = LINE_IDLE;
        if (accept) begin
          state_d = START;
          sh_d = data_in;
          idx_d = '0;
          tx_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          par_d = ^data_in;
`endif
        end
      end
      START: if (period_end) begin
        state_d = DATA;
        tx_d = sh_q[0];
      end
      DATA: if (period_end) begin
        if (idx_q == IW'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
          tx_d = par_q;
`else
          state_d = STOP;
          tx_d = LINE_IDLE;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
          sh_d = sh_q >> 1;
          tx_d = sh_d[0];
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (period_end) begin
        state_d = STOP;
        tx_d = LINE_IDLE;
      end
`endif
      STOP: if (period_end) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d = LINE_IDLE;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      idx_q <= '0;
      tx_q <= LINE_IDLE;
      done_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      tx_q <= tx_d;
      done_q <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed checks of serial_frame_tx with CLKS_PER_BIT=4, DATA_W=8.
module tb_serial_frame_tx;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = 44;
`else
  localparam int FL = 40;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic tx_out, busy, done;
  int checks = 0;
  int fails = 0;
  serial_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .send(send),
    .data_in(data_in),
    .tx_out(tx_out),
    .busy(busy),
    .done(done)
  );
  always #5 clock = ~clock;
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef SERIAL_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction
  // starts at a negedge; returns at the negedge of the done cycle (cycle FL after acceptance)
  task automatic run_frame(input logic [7:0] d, input int hold, input int inj, input string name);
    send = 1'b1;
    data_in = d;
    for (int k = 0; k <= FL; k++) begin
      @(negedge clock);
      if (k < FL) begin
        checks++;
        if (tx_out !== exp_bit(d, k)) begin
          fails++;
          $display("FAIL %s tx cycle %0d: got %b want %b", name, k, tx_out, exp_bit(d, k));
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          fails++;
          $display("FAIL %s busy/done cycle %0d: got %b/%b want 1/0", name, k, busy, done);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
          fails++;
          $display("FAIL %s end cycle %0d: done/busy/tx got %b/%b/%b want 1/0/1", name, k, done, busy, tx_out);
        end
      end
      send = (k < hold - 1) || (k == inj);
      if (k == inj) data_in = 8'hFF;
    end
  endtask
  task automatic check_idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s idle cycle %0d: tx/busy/done got %b/%b/%b want 1/0/0", name, i, tx_out, busy, done);
      end
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: tx/busy/done got %b/%b/%b want 1/0/0", tx_out, busy, done);
    end
    reset = 1'b0;
    check_idle(50, "reset_idle");
  endtask
  task automatic test_frames;
    run_frame(8'hA5, 1, -1, "frame_a5");
    check_idle(2, "after_a5");
    run_frame(8'h00, 1, -1, "frame_00");
    check_idle(2, "after_00");
    run_frame(8'h81, 1, -1, "frame_81");
    check_idle(2, "after_81");
  endtask
  task automatic test_ignore_busy;
    run_frame(8'hA5, 1, 10, "ignore_busy");
    data_in = 8'h00;
    check_idle(3, "after_ignore");
  endtask
  task automatic test_ignore_done;
    run_frame(8'h5A, 1, -1, "pre_done");
    send = 1'b1;
    data_in = 8'h55;
    @(negedge clock);
    send = 1'b0;
    check_idle(6, "done_cycle_send");
  endtask
  task automatic test_reset_mid;
    send = 1'b1;
    data_in = 8'hA5;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      send = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: tx/busy/done got %b/%b/%b want 1/0/0", tx_out, busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    check_idle(45, "post_reset");
    run_frame(8'h3C, 1, -1, "frame_3c");
    check_idle(2, "after_3c");
  endtask
  task automatic test_back_to_back;
    run_frame(8'hC3, 6, -1, "b2b_first");
    check_idle(1, "b2b_gap");
    run_frame(8'h96, 1, -1, "b2b_second");
    check_idle(3, "b2b_after");
  endtask
`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity;
    run_frame(8'h07, 1, -1, "parity_07");
    check_idle(2, "after_p07");
    run_frame(8'h03, 1, -1, "parity_03");
    check_idle(2, "after_p03");
  endtask
`endif
  initial begin
    test_reset;
    test_frames;
    test_ignore_busy;
    test_ignore_done;
    test_reset_mid;
    test_back_to_back;
`ifdef SERIAL_TX_PARITY_EN
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
